data_cache_dm: RTL and testbench
================================

DATA_CACHE_DM -- requirements
Module: data_cache_dm

Interface
REQ-001 SHALL have parameter NUM_LINES, default 64, meaning number of direct-mapped lines (power of 2, >=2).
REQ-002 SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per line (power of 2, >=2).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-004 SHALL have port i_Clock, in, 1, clock; all state updates on the rising edge.
REQ-005 SHALL have port i_Reset, in, 1, synchronous, active-high reset.
REQ-006 SHALL have port i_Valid, in, 1, CPU request present.
REQ-007 SHALL have port i_WriteEnable, in, 1, 1=store, 0=load.
REQ-008 SHALL have port i_Size, in, 2, 00=byte, 01=halfword, 10=word; 11 is treated as word.
REQ-009 SHALL have port i_Unsigned, in, 1, load zero-extends when 1 and sign-extends when 0.
REQ-010 SHALL have port i_Address, in, ADDR_WIDTH, byte address.
REQ-011 SHALL have port i_DataIn, in, 32, store data, right-aligned.
REQ-012 SHALL have port o_Ready, out, 1, request accepted in any cycle where i_Valid&&o_Ready.
REQ-013 SHALL have port o_DataValid, out, 1, one-cycle pulse qualifying o_DataOut.
REQ-014 SHALL have port o_DataOut, out, 32, extended load result.
REQ-015 SHALL have port o_AddressMisaligned, out, 1, one-cycle fault pulse.
REQ-016 SHALL have ports o_MemReadReq (out, 1), o_MemAddress (out, ADDR_WIDTH), i_MemReadValid (in, 1) and i_MemReadData (in, 32), the backing-memory read channel.
REQ-017 SHALL have ports o_MemWriteReq (out, 1), o_MemWriteData (out, 32), o_MemWriteStrobe (out, 4) and i_MemWriteAck (in, 1), the backing-memory write channel.

Function
REQ-018 Address split SHALL be: byte offset [1:0]; word-in-line [log2(LINE_WORDS)+1:2]; index next log2(NUM_LINES) bits; tag = remaining upper bits.
REQ-019 The FSM SHALL have states IDLE, REFILL and WRITE, and o_Ready SHALL be 1 only in IDLE.
REQ-020 Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-021 An accepted misaligned request SHALL:
- pulse o_AddressMisaligned on the next cycle;
- leave o_DataValid at 0;
- leave cache and memory untouched;
- stay in IDLE.
REQ-022 An accepted aligned load hit (line valid, tag equal) SHALL pulse o_DataValid with data on the next cycle, giving 1-cycle latency and back-to-back throughput.
REQ-023 An accepted load miss SHALL latch the request and enter REFILL; o_MemReadReq=1 and o_MemAddress=line base address SHALL be held until LINE_WORDS beats have been received.
REQ-024 Each i_MemReadValid beat in REFILL SHALL write the next word of the line, incrementing from word 0 with a counter wrapping at LINE_WORDS.
REQ-025 On the last beat the FSM SHALL set the tag and valid bit and return to IDLE; the next cycle SHALL pulse o_DataValid with the requested word taken from the refilled line.
REQ-026 Load extraction SHALL be:
- byte = lane addr[1:0];
- halfword = lane addr[1];
- sign/zero extension from bit 7/15 per i_Unsigned.
REQ-027 Stores SHALL be write-through with no write-allocate; on a hit only the strobed bytes of the cached word SHALL be updated, in the acceptance cycle.
REQ-028 An accepted aligned store SHALL enter WRITE with o_MemWriteReq=1 held until i_MemWriteAck, then return to IDLE; stores SHALL never pulse o_DataValid.
REQ-029 In WRITE, o_MemAddress SHALL be the word-aligned address.
REQ-030 o_MemWriteStrobe SHALL be 0001<<addr[1:0] for a byte store, 0011<<addr[1:0] for a halfword store, and 1111 for a word store.
REQ-031 o_MemWriteData SHALL replicate the store data: the byte on all four lanes, or the halfword on both halves.
REQ-032 An ack arriving in the first cycle of a request SHALL complete that request, giving a minimum 2-cycle store occupancy.
REQ-033 i_MemReadValid outside REFILL and i_MemWriteAck outside WRITE SHALL be ignored.
REQ-034 i_Valid while o_Ready=0 SHALL NOT be accepted; the requester holds the request.

Reset
REQ-035 On reset the FSM SHALL enter IDLE and all valid bits SHALL clear in one cycle.
REQ-036 On reset o_DataOut, o_DataValid, o_AddressMisaligned, o_MemReadReq, o_MemWriteReq and o_MemWriteStrobe SHALL be 0, and the beat counter SHALL be 0.
REQ-037 Reset mid-REFILL SHALL abandon the refill and leave the line invalid.
REQ-038 Reset mid-WRITE SHALL drop the request; the write is not retried.
REQ-039 A load issued after reset SHALL always miss.

Verification
REQ-040 Cold-miss test: reset, then word load 0x100 with memory beats 0x11,0x22,0x33,0x44 -> 4 beats at base 0x100, o_DataValid one cycle after the last beat, o_DataOut=0x11; a repeat load of 0x10C SHALL hit in 1 cycle with 0x44.
REQ-041 Load-extension test: line holding 0x8081F0FF at 0x200 -> signed byte @0x200=0xFFFFFFFF, unsigned byte @0x201=0x000000F0, signed half @0x202=0xFFFF8081, unsigned half @0x202=0x00008081.
REQ-042 Store-hit test: byte store 0xAB to 0x203 on a cached line -> strobe 1000, data 0xABABABAB, held until ack after 3 cycles; a later word load of 0x200 SHALL return 0xAB81F0FF with no refill.
REQ-043 Store-miss test: store to an uncached line -> memory write only; the next load to that line SHALL miss.
REQ-044 Misaligned test: word load at 0x102 -> o_AddressMisaligned pulse, no o_DataValid, no memory request, o_Ready stays 1.
REQ-045 Reset-mid-refill test: assert reset after 2 of 4 beats -> outputs zero; reloading the same address SHALL miss and perform the full 4-beat refill.

Source files
------------

// File: rtl/data_cache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with a
// line-burst refill channel and a single-beat write channel.
module data_cache_dm #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Valid,
    input  logic                  i_WriteEnable,
    input  logic [1:0]            i_Size,
    input  logic                  i_Unsigned,
    input  logic [ADDR_WIDTH-1:0] i_Address,
    input  logic [31:0]           i_DataIn,
    output logic                  o_Ready,
    output logic                  o_DataValid,
    output logic [31:0]           o_DataOut,
    output logic                  o_AddressMisaligned,
    output logic                  o_MemReadReq,
    output logic [ADDR_WIDTH-1:0] o_MemAddress,
    input  logic                  i_MemReadValid,
    input  logic [31:0]           i_MemReadData,
    output logic                  o_MemWriteReq,
    output logic [31:0]           o_MemWriteData,
    output logic [3:0]            o_MemWriteStrobe,
    input  logic                  i_MemWriteAck
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int IDX_LO = OFF_W + 2;
    localparam int TAG_LO = IDX_LO + IDX_W;
    localparam int TAG_W  = ADDR_WIDTH - TAG_LO;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;

    state_e                  state_q, state_d;
    logic [OFF_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [1:0]              req_size_q, req_size_d;
    logic                    req_unsigned_q, req_unsigned_d;
    logic [31:0]             wr_data_q, wr_data_d;
    logic [3:0]              wr_strobe_q, wr_strobe_d;
    logic [31:0]             data_out_q, data_out_d;
    logic                    data_valid_q, data_valid_d;
    logic                    misaligned_q, misaligned_d;
    logic [NUM_LINES-1:0]    valid_q, valid_d;

    logic [31:0]             data_mem_q [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]        tag_mem_q  [NUM_LINES];

    logic                    mem_we;
    logic [IDX_W-1:0]        mem_line;
    logic [OFF_W-1:0]        mem_word;
    logic [31:0]             mem_wdata;
    logic [3:0]              mem_wstrb;
    logic                    tag_we;

    logic [TAG_W-1:0]        in_tag, req_tag;
    logic [IDX_W-1:0]        in_idx, req_idx;
    logic [OFF_W-1:0]        in_word, req_word;
    logic                    in_hit, in_misaligned;
    logic [31:0]             in_repl, fill_word;
    logic [3:0]              in_strobe;

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   load_extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   load_extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_extract = w;
        endcase
    endfunction

    assign in_tag   = i_Address[ADDR_WIDTH-1:TAG_LO];
    assign in_idx   = i_Address[TAG_LO-1:IDX_LO];
    assign in_word  = i_Address[IDX_LO-1:2];
    assign req_tag  = req_addr_q[ADDR_WIDTH-1:TAG_LO];
    assign req_idx  = req_addr_q[TAG_LO-1:IDX_LO];
    assign req_word = req_addr_q[IDX_LO-1:2];

    assign in_hit = valid_q[in_idx] && (tag_mem_q[in_idx] == in_tag);
    assign in_misaligned = (i_Size == 2'b01) ? i_Address[0] :
                           (i_Size[1])       ? (i_Address[1:0] != 2'b00) : 1'b0;

    always_comb begin
        case (i_Size)
            2'b00: begin
                in_repl   = {4{i_DataIn[7:0]}};
                in_strobe = 4'b0001 << i_Address[1:0];
            end
            2'b01: begin
                in_repl   = {2{i_DataIn[15:0]}};
                in_strobe = 4'b0011 << i_Address[1:0];
            end
            default: begin
                in_repl   = i_DataIn;
                in_strobe = 4'b1111;
            end
        endcase
    end

    // The requested word may be arriving on this very beat, so bypass the array.
    assign fill_word = (req_word == beat_cnt_q) ? i_MemReadData : data_mem_q[req_idx][req_word];

    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        req_addr_d     = req_addr_q;
        req_size_d     = req_size_q;
        req_unsigned_d = req_unsigned_q;
        wr_data_d      = wr_data_q;
        wr_strobe_d    = wr_strobe_q;
        data_out_d     = data_out_q;
        data_valid_d   = 1'b0;
        misaligned_d   = 1'b0;
        valid_d        = valid_q;
        mem_we         = 1'b0;
        mem_line       = in_idx;
        mem_word       = in_word;
        mem_wdata      = in_repl;
        mem_wstrb      = in_strobe;
        tag_we         = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_Valid) begin
                    if (in_misaligned) begin
                        misaligned_d = 1'b1;
                    end else if (i_WriteEnable) begin
                        req_addr_d  = i_Address;
                        wr_data_d   = in_repl;
                        wr_strobe_d = in_strobe;
                        state_d     = WRITE;
                        mem_we      = in_hit;
                    end else if (in_hit) begin
                        data_out_d   = load_extract(data_mem_q[in_idx][in_word], i_Address[1:0],
                                                    i_Size, i_Unsigned);
                        data_valid_d = 1'b1;
                    end else begin
                        req_addr_d      = i_Address;
                        req_size_d      = i_Size;
                        req_unsigned_d  = i_Unsigned;
                        beat_cnt_d      = '0;
                        valid_d[in_idx] = 1'b0;
                        state_d         = REFILL;
                    end
                end
            end
            REFILL: begin
                mem_line  = req_idx;
                mem_word  = beat_cnt_q;
                mem_wdata = i_MemReadData;
                mem_wstrb = 4'b1111;
                if (i_MemReadValid) begin
                    mem_we     = 1'b1;
                    beat_cnt_d = beat_cnt_q + OFF_W'(1);
                    if (beat_cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                        valid_d[req_idx] = 1'b1;
                        tag_we           = 1'b1;
                        data_out_d       = load_extract(fill_word, req_addr_q[1:0],
                                                        req_size_q, req_unsigned_q);
                        data_valid_d     = 1'b1;
                        state_d          = IDLE;
                    end
                end
            end
            WRITE: begin
                if (i_MemWriteAck) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q        <= IDLE;
            beat_cnt_q     <= '0;
            req_addr_q     <= '0;
            req_size_q     <= '0;
            req_unsigned_q <= 1'b0;
            wr_data_q      <= '0;
            wr_strobe_q    <= '0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            misaligned_q   <= 1'b0;
            valid_q        <= '0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            req_addr_q     <= req_addr_d;
            req_size_q     <= req_size_d;
            req_unsigned_q <= req_unsigned_d;
            wr_data_q      <= wr_data_d;
            wr_strobe_q    <= wr_strobe_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            misaligned_q   <= misaligned_d;
            valid_q        <= valid_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset && mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) begin
                    data_mem_q[mem_line][mem_word][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
        if (!i_Reset && tag_we) begin
            tag_mem_q[req_idx] <= req_tag;
        end
    end

    assign o_Ready             = (state_q == IDLE);
    assign o_DataValid         = data_valid_q;
    assign o_DataOut           = data_out_q;
    assign o_AddressMisaligned = misaligned_q;
    assign o_MemReadReq        = (state_q == REFILL);
    assign o_MemWriteReq       = (state_q == WRITE);
    assign o_MemWriteData      = wr_data_q;
    assign o_MemWriteStrobe    = (state_q == WRITE) ? wr_strobe_q : 4'b0000;

    always_comb begin
        case (state_q)
            REFILL:  o_MemAddress = {req_addr_q[ADDR_WIDTH-1:IDX_LO], {IDX_LO{1'b0}}};
            WRITE:   o_MemAddress = {req_addr_q[ADDR_WIDTH-1:2], 2'b00};
            default: o_MemAddress = '0;
        endcase
    end

endmodule

// File: tb/tb_data_cache_dm.sv
// Directed self-checking bench for data_cache_dm: one task per scenario,
// inputs driven 1 ns after the rising edge and outputs sampled there too.
module tb_data_cache_dm;

    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b0;
    logic        i_Valid = 1'b0;
    logic        i_WriteEnable = 1'b0;
    logic [1:0]  i_Size = 2'b10;
    logic        i_Unsigned = 1'b0;
    logic [31:0] i_Address = '0;
    logic [31:0] i_DataIn = '0;
    logic        o_Ready, o_DataValid, o_AddressMisaligned, o_MemReadReq, o_MemWriteReq;
    logic [31:0] o_DataOut, o_MemAddress, o_MemWriteData;
    logic [3:0]  o_MemWriteStrobe;
    logic        i_MemReadValid = 1'b0;
    logic [31:0] i_MemReadData = '0;
    logic        i_MemWriteAck = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    data_cache_dm #(.NUM_LINES(64), .LINE_WORDS(4), .ADDR_WIDTH(32)) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Valid(i_Valid), .i_WriteEnable(i_WriteEnable),
        .i_Size(i_Size), .i_Unsigned(i_Unsigned), .i_Address(i_Address), .i_DataIn(i_DataIn),
        .o_Ready(o_Ready), .o_DataValid(o_DataValid), .o_DataOut(o_DataOut),
        .o_AddressMisaligned(o_AddressMisaligned), .o_MemReadReq(o_MemReadReq),
        .o_MemAddress(o_MemAddress), .i_MemReadValid(i_MemReadValid), .i_MemReadData(i_MemReadData),
        .o_MemWriteReq(o_MemWriteReq), .o_MemWriteData(o_MemWriteData),
        .o_MemWriteStrobe(o_MemWriteStrobe), .i_MemWriteAck(i_MemWriteAck)
    );

    always #5 i_Clock = ~i_Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data);
        i_Valid = 1'b1; i_WriteEnable = we; i_Size = size; i_Unsigned = uns;
        i_Address = addr; i_DataIn = data;
    endtask

    task automatic idle_req();
        i_Valid = 1'b0; i_WriteEnable = 1'b0;
    endtask

    task automatic test_reset();
        i_Reset = 1'b1;
        tick(); tick();
        n_cmp++; if (o_Ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", o_Ready); end
        n_cmp++; if (o_DataValid !== 1'b0) begin n_fail++; $display("FAIL rst_dvalid: got %b expected 0", o_DataValid); end
        n_cmp++; if (o_DataOut !== 32'h0) begin n_fail++; $display("FAIL rst_dout: got %h expected 0", o_DataOut); end
        n_cmp++; if (o_MemReadReq !== 1'b0) begin n_fail++; $display("FAIL rst_rdreq: got %b expected 0", o_MemReadReq); end
        n_cmp++; if (o_MemWriteReq !== 1'b0) begin n_fail++; $display("FAIL rst_wrreq: got %b expected 0", o_MemWriteReq); end
        n_cmp++; if (o_MemWriteStrobe !== 4'h0) begin n_fail++; $display("FAIL rst_strobe: got %b expected 0000", o_MemWriteStrobe); end
        n_cmp++; if (o_AddressMisaligned !== 1'b0) begin n_fail++; $display("FAIL rst_misal: got %b expected 0", o_AddressMisaligned); end
        i_Reset = 1'b0;
    endtask

    task automatic test_cold_miss();
        logic [31:0] beats [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        tick();
        idle_req();
        n_cmp++; if (o_Ready !== 1'b0) begin n_fail++; $display("FAIL miss_ready: got %b expected 0", o_Ready); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (o_MemReadReq !== 1'b1) begin n_fail++; $display("FAIL miss_rdreq%0d: got %b expected 1", i, o_MemReadReq); end
            n_cmp++; if (o_MemAddress !== 32'h100) begin n_fail++; $display("FAIL miss_addr%0d: got %h expected 00000100", i, o_MemAddress); end
            n_cmp++; if (o_DataValid !== 1'b0) begin n_fail++; $display("FAIL miss_early_dv%0d: got %b expected 0", i, o_DataValid); end
            if (i == 2) begin
                tick();  // one-cycle gap in the beat stream
                n_cmp++; if (o_MemReadReq !== 1'b1) begin n_fail++; $display("FAIL miss_gap_rdreq: got %b expected 1", o_MemReadReq); end
            end
            i_MemReadValid = 1'b1; i_MemReadData = beats[i];
            tick();
            i_MemReadValid = 1'b0;
        end
        n_cmp++; if (o_DataValid !== 1'b1) begin n_fail++; $display("FAIL miss_dv: got %b expected 1", o_DataValid); end
        n_cmp++; if (o_DataOut !== 32'h11) begin n_fail++; $display("FAIL miss_dout: got %h expected 00000011", o_DataOut); end
        n_cmp++; if (o_MemReadReq !== 1'b0) begin n_fail++; $display("FAIL miss_rdreq_end: got %b expected 0", o_MemReadReq); end
        issue(1'b0, 2'b10, 1'b0, 32'h10C, 32'h0);
        tick();
        idle_req();
        n_cmp++; if (o_DataValid !== 1'b1) begin n_fail++; $display("FAIL hit_dv: got %b expected 1", o_DataValid); end
        n_cmp++; if (o_DataOut !== 32'h44) begin n_fail++; $display("FAIL hit_dout: got %h expected 00000044", o_DataOut); end
        n_cmp++; if (o_MemReadReq !== 1'b0) begin n_fail++; $display("FAIL hit_rdreq: got %b expected 0", o_MemReadReq); end
        tick();
        n_cmp++; if (o_DataValid !== 1'b0) begin n_fail++; $display("FAIL hit_dv_pulse: got %b expected 0", o_DataValid); end
    endtask

    task automatic test_load_extension();
        logic [31:0] beats [4] = '{32'h8081F0FF, 32'h1, 32'h2, 32'h3};
        logic [31:0] addrs [4] = '{32'h200, 32'h201, 32'h202, 32'h202};
        logic [1:0]  sizes [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        uns   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exps  [4] = '{32'hFFFFFFFF, 32'h000000F0, 32'hFFFF8081, 32'h00008081};
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        tick();
        idle_req();
        for (int i = 0; i < 4; i++) begin
            i_MemReadValid = 1'b1; i_MemReadData = beats[i];
            tick();
        end
        i_MemReadValid = 1'b0;
        n_cmp++; if (o_DataOut !== 32'h8081F0FF || o_DataValid !== 1'b1) begin n_fail++; $display("FAIL ext_fill: got %b/%h expected 1/8081f0ff", o_DataValid, o_DataOut); end
        // back-to-back hits, one request per cycle
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, sizes[i], uns[i], addrs[i], 32'h0);
            tick();
            n_cmp++; if (o_DataValid !== 1'b1 || o_DataOut !== exps[i]) begin n_fail++; $display("FAIL ext%0d: got %b/%h expected 1/%h", i, o_DataValid, o_DataOut, exps[i]); end
        end
        idle_req();
    endtask

    task automatic test_store_hit();
        issue(1'b1, 2'b00, 1'b0, 32'h203, 32'h000000AB);
        tick();
        idle_req();
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (o_MemWriteReq !== 1'b1) begin n_fail++; $display("FAIL sth_wrreq%0d: got %b expected 1", c, o_MemWriteReq); end
            n_cmp++; if (o_MemWriteStrobe !== 4'b1000) begin n_fail++; $display("FAIL sth_strobe%0d: got %b expected 1000", c, o_MemWriteStrobe); end
            n_cmp++; if (o_MemWriteData !== 32'hABABABAB) begin n_fail++; $display("FAIL sth_data%0d: got %h expected abababab", c, o_MemWriteData); end
            n_cmp++; if (o_MemAddress !== 32'h200) begin n_fail++; $display("FAIL sth_addr%0d: got %h expected 00000200", c, o_MemAddress); end
            n_cmp++; if (o_Ready !== 1'b0 || o_DataValid !== 1'b0) begin n_fail++; $display("FAIL sth_busy%0d: got rdy %b dv %b expected 0/0", c, o_Ready, o_DataValid); end
            i_MemWriteAck = (c == 2);
            tick();
        end
        i_MemWriteAck = 1'b0;
        n_cmp++; if (o_MemWriteReq !== 1'b0 || o_Ready !== 1'b1) begin n_fail++; $display("FAIL sth_done: got req %b rdy %b expected 0/1", o_MemWriteReq, o_Ready); end
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        tick();
        idle_req();
        n_cmp++; if (o_DataValid !== 1'b1 || o_DataOut !== 32'hAB81F0FF) begin n_fail++; $display("FAIL sth_reload: got %b/%h expected 1/ab81f0ff", o_DataValid, o_DataOut); end
        n_cmp++; if (o_MemReadReq !== 1'b0) begin n_fail++; $display("FAIL sth_norefill: got %b expected 0", o_MemReadReq); end
    endtask

    task automatic test_store_miss();
        issue(1'b1, 2'b10, 1'b0, 32'h400, 32'hDEADBEEF);
        tick();
        n_cmp++; if (o_MemWriteReq !== 1'b1 || o_MemWriteStrobe !== 4'b1111 || o_MemWriteData !== 32'hDEADBEEF || o_MemAddress !== 32'h400)
            begin n_fail++; $display("FAIL stm_word: got %b %b %h %h expected 1 1111 deadbeef 00000400", o_MemWriteReq, o_MemWriteStrobe, o_MemWriteData, o_MemAddress); end
        // this request is held in the driver but o_Ready is low, so it is not taken
        issue(1'b1, 2'b01, 1'b0, 32'h402, 32'h00001234);
        i_MemWriteAck = 1'b1;
        tick();
        i_MemWriteAck = 1'b0;
        n_cmp++; if (o_MemWriteReq !== 1'b0 || o_Ready !== 1'b1) begin n_fail++; $display("FAIL stm_min2: got req %b rdy %b expected 0/1", o_MemWriteReq, o_Ready); end
        tick();
        idle_req();
        n_cmp++; if (o_MemWriteStrobe !== 4'b1100 || o_MemWriteData !== 32'h12341234 || o_MemAddress !== 32'h400)
            begin n_fail++; $display("FAIL stm_half: got %b %h %h expected 1100 12341234 00000400", o_MemWriteStrobe, o_MemWriteData, o_MemAddress); end
        i_MemWriteAck = 1'b1;
        tick();
        i_MemWriteAck = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h404, 32'h0);
        tick();
        idle_req();
        n_cmp++; if (o_MemReadReq !== 1'b1 || o_DataValid !== 1'b0 || o_MemAddress !== 32'h400)
            begin n_fail++; $display("FAIL stm_nowa: got req %b dv %b addr %h expected 1 0 00000400", o_MemReadReq, o_DataValid, o_MemAddress); end
        for (int i = 0; i < 4; i++) begin
            i_MemReadValid = 1'b1; i_MemReadData = 32'hA0 + i;
            tick();
        end
        i_MemReadValid = 1'b0;
        n_cmp++; if (o_DataValid !== 1'b1 || o_DataOut !== 32'hA1) begin n_fail++; $display("FAIL stm_fill: got %b/%h expected 1/000000a1", o_DataValid, o_DataOut); end
    endtask

    task automatic test_misaligned();
        issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
        tick();
        idle_req();
        n_cmp++; if (o_AddressMisaligned !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b expected 1", o_AddressMisaligned); end
        n_cmp++; if (o_DataValid !== 1'b0 || o_MemReadReq !== 1'b0 || o_Ready !== 1'b1)
            begin n_fail++; $display("FAIL mis_side: got dv %b rd %b rdy %b expected 0 0 1", o_DataValid, o_MemReadReq, o_Ready); end
        issue(1'b1, 2'b01, 1'b0, 32'h201, 32'h5555);
        tick();
        idle_req();
        n_cmp++; if (o_AddressMisaligned !== 1'b1 || o_MemWriteReq !== 1'b0)
            begin n_fail++; $display("FAIL mis_store: got mis %b wr %b expected 1 0", o_AddressMisaligned, o_MemWriteReq); end
        tick();
        n_cmp++; if (o_AddressMisaligned !== 1'b0) begin n_fail++; $display("FAIL mis_oneshot: got %b expected 0", o_AddressMisaligned); end
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        tick();
        idle_req();
        n_cmp++; if (o_DataOut !== 32'hAB81F0FF) begin n_fail++; $display("FAIL mis_untouched: got %h expected ab81f0ff", o_DataOut); end
    endtask

    task automatic test_reset_mid_refill();
        issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        tick();
        idle_req();
        for (int i = 0; i < 2; i++) begin
            i_MemReadValid = 1'b1; i_MemReadData = 32'hC0 + i;
            tick();
        end
        i_MemReadValid = 1'b0;
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        n_cmp++; if (o_MemReadReq !== 1'b0 || o_DataValid !== 1'b0 || o_DataOut !== 32'h0 || o_Ready !== 1'b1)
            begin n_fail++; $display("FAIL rmr_zero: got rd %b dv %b dout %h rdy %b expected 0 0 0 1", o_MemReadReq, o_DataValid, o_DataOut, o_Ready); end
        issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        tick();
        idle_req();
        n_cmp++; if (o_MemReadReq !== 1'b1 || o_MemAddress !== 32'h300) begin n_fail++; $display("FAIL rmr_miss: got %b %h expected 1 00000300", o_MemReadReq, o_MemAddress); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (o_DataValid !== 1'b0) begin n_fail++; $display("FAIL rmr_early%0d: got %b expected 0", i, o_DataValid); end
            i_MemReadValid = 1'b1; i_MemReadData = 32'hD0 + i;
            tick();
        end
        i_MemReadValid = 1'b0;
        n_cmp++; if (o_DataValid !== 1'b1 || o_DataOut !== 32'hD0) begin n_fail++; $display("FAIL rmr_fill: got %b/%h expected 1/000000d0", o_DataValid, o_DataOut); end
        // a line cached before the reset must miss now
        issue(1'b0, 2'b10, 1'b0, 32'h10C, 32'h0);
        tick();
        idle_req();
        n_cmp++; if (o_MemReadReq !== 1'b1 || o_DataValid !== 1'b0) begin n_fail++; $display("FAIL rmr_cold: got rd %b dv %b expected 1 0", o_MemReadReq, o_DataValid); end
        for (int i = 0; i < 4; i++) begin
            i_MemReadValid = 1'b1; i_MemReadData = 32'hE0 + i;
            tick();
        end
        i_MemReadValid = 1'b0;
        n_cmp++; if (o_DataValid !== 1'b1 || o_DataOut !== 32'hE3) begin n_fail++; $display("FAIL rmr_cold_fill: got %b/%h expected 1/000000e3", o_DataValid, o_DataOut); end
    endtask

    initial begin
        tick();
        test_reset();
        test_cold_miss();
        test_load_extension();
        test_store_hit();
        test_store_miss();
        test_misaligned();
        test_reset_mid_refill();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
